usb_in_arbiter: RTL and testbench

- Round-robin arbiter that shares the single usb_cdc IN byte stream (in_data/in_valid/in_ready) between CHANNELS application byte sources.
- Sits in the app clock domain, between the app-side producers and the usb_cdc IN interface.
- Grants one channel at a time for a burst of up to MAX_BURST bytes, so a host IN packet is not interleaved within a burst.
- Drives a registered output stage toward usb_cdc.

---
 rtl/usb_in_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_usb_in_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter
//   Round-robin arbiter that shares one usb_cdc IN byte stream between
//   CHANNELS application byte sources. A channel keeps the grant for a burst
//   of up to MAX_BURST bytes. The burst ends early when the channel stops
//   presenting data. The output toward usb_cdc is a registered valid/ready
//   stage.
//
//   Optional feature: define USB_IN_ARBITER_TAG_EN to emit one tag byte
//   (TAG_BASE | channel index) at the start of every grant. Without the
//   macro the stream carries data only and TAG_BASE is unused.
//
// Ports
//   clk_i        app clock, rising edge
//   rstn_i       synchronous active-low reset
//   req_data_i   byte per channel, channel k at [8k+7:8k]
//   req_valid_i  channel k has a byte
//   req_ready_o  channel k byte accepted when valid & ready
//   in_data_o    byte to usb_cdc
//   in_valid_o   valid to usb_cdc
//   in_ready_i   ready from usb_cdc
//   grant_o      one-hot current grant, zero when idle
//   busy_o       high while an arbitration grant is active
module usb_in_arbiter #(
    parameter int         CHANNELS  = 2,
    parameter int         MAX_BURST = 8,
    parameter logic [7:0] TAG_BASE  = 8'hF0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [8*CHANNELS-1:0] req_data_i,
    input  logic [CHANNELS-1:0]   req_valid_i,
    output logic [CHANNELS-1:0]   req_ready_o,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    output logic [CHANNELS-1:0]   grant_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef USB_IN_ARBITER_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TAG = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;
`endif

    state_t              state_reg, state_next;
    logic [CHANNELS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]    gidx_reg, gidx_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic                out_valid_reg, out_valid_next;
    logic [7:0]          out_data_reg, out_data_next;

    logic                free;
    logic                accept;
    logic                load;
    logic [7:0]          load_data;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [SUM_W-1:0]    cand_sum;
    logic [7:0]          chan_data [CHANNELS];

    // The output register can take a new byte when it is empty or draining.
    assign free   = ~out_valid_reg | in_ready_i;
    assign accept = (state_reg == GRANT) && free && req_valid_i[gidx_reg];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan_data[gi]   = req_data_i[8*gi +: 8];
            // Ready follows the output register directly so a byte is taken
            // in the same cycle the downstream drains.
            assign req_ready_o[gi] = (state_reg == GRANT) &&
                                     (gidx_reg == IDX_W'(gi)) && free;
        end
    endgenerate

    // Round-robin search: start one past the last granted channel and take
    // the first requester, wrapping modulo CHANNELS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand_sum = {1'b0, ptr_reg} + SUM_W'(k);
            if (cand_sum >= SUM_W'(CHANNELS)) begin
                cand_sum = cand_sum - SUM_W'(CHANNELS);
            end
            if (!win_found && req_valid_i[IDX_W'(cand_sum)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand_sum);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        gidx_next      = gidx_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        load           = 1'b0;
        load_data      = 8'h00;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    gidx_next  = win_idx;
                    grant_next = {{(CHANNELS-1){1'b0}}, 1'b1} << win_idx;
                    cnt_next   = '0;
`ifdef USB_IN_ARBITER_TAG_EN
                    state_next = TAG;
`else
                    state_next = GRANT;
`endif
                end
            end
`ifdef USB_IN_ARBITER_TAG_EN
            TAG: begin
                // The tag byte is not part of the burst count.
                if (free) begin
                    load       = 1'b1;
                    load_data  = TAG_BASE | 8'(gidx_reg);
                    state_next = GRANT;
                end
            end
`endif
            GRANT: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = chan_data[gidx_reg];
                    cnt_next  = cnt_reg + CNT_W'(1);
                end
                // Release at the burst limit, or on a requester gap. A gap is
                // only seen while the output can move, so backpressure freezes
                // the grant.
                if ((accept && (cnt_reg == CNT_W'(MAX_BURST - 1))) ||
                    (free && !req_valid_i[gidx_reg])) begin
                    state_next = IDLE;
                    ptr_next   = gidx_reg;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = load_data;
        end else if (in_ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            gidx_reg      <= '0;
            cnt_reg       <= '0;
            ptr_reg       <= IDX_W'(CHANNELS - 1);
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            gidx_reg      <= gidx_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign in_valid_o = out_valid_reg;
    assign in_data_o  = out_data_reg;
    assign grant_o    = grant_reg;
    assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Testbench for usb_in_arbiter (CHANNELS=2, MAX_BURST=8).
module tb_usb_in_arbiter;

    localparam int         C  = 2;
    localparam int         MB = 8;
    localparam logic [7:0] TB = 8'hF0;
`ifdef USB_IN_ARBITER_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [8*C-1:0] req_data;
    logic [C-1:0]   req_valid;
    logic [C-1:0]   req_ready;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic [C-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    usb_in_arbiter #(.CHANNELS(C), .MAX_BURST(MB), .TAG_BASE(TB)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
        .grant_o(grant), .busy_o(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] out_log[$];
    int         out_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit bit_of(input logic [C-1:0] v, input int i);
        logic [C-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*C-1:0] v, input int i);
        logic [8*C-1:0] s;
        s = v >> (8 * i);
        return s[7:0];
    endfunction

    // Reference model: the arbiter described by its rules. State 0 = idle,
    // 1 = granted, 2 = tag pending.
    int         m_state = 0;
    int         m_owner = 0;
    int         m_cnt   = 0;
    int         m_ptr   = C - 1;
    bit         m_ov    = 1'b0;
    logic [7:0] m_od    = 8'h00;

    always @(posedge clk) begin : model
        int         ns, no, nc, np, c;
        bit         fr, ld, nov;
        logic [7:0] b, nod;
        fr = !m_ov || in_ready;
        ld = 1'b0;
        b  = 8'h00;
        ns = m_state; no = m_owner; nc = m_cnt; np = m_ptr;
        if (!rstn) begin
            ns = 0; no = 0; nc = 0; np = C - 1; nov = 1'b0; nod = 8'h00;
        end else begin
            if (m_state == 0) begin
                for (int k = 1; k <= C; k++) begin
                    c = (m_ptr + k) % C;
                    if (ns == 0 && bit_of(req_valid, c)) begin
                        no = c; nc = 0; ns = TAG_EN ? 2 : 1;
                    end
                end
            end else if (m_state == 2) begin
                if (fr) begin
                    ld = 1'b1; b = TB | 8'(m_owner); ns = 1;
                end
            end else begin
                if (fr && bit_of(req_valid, m_owner)) begin
                    ld = 1'b1; b = byte_of(req_data, m_owner); nc = m_cnt + 1;
                    if (nc == MB) begin ns = 0; np = m_owner; end
                end else if (fr) begin
                    ns = 0; np = m_owner;
                end
            end
            nov = ld ? 1'b1 : (in_ready ? 1'b0 : m_ov);
            nod = ld ? b : m_od;
        end
        m_state <= ns; m_owner <= no; m_cnt <= nc; m_ptr <= np;
        m_ov <= nov; m_od <= nod;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin : compare
        logic         fr;
        logic [C-1:0] eg, er;
        if (chk_en) begin
            fr = !m_ov || in_ready;
            eg = (m_state != 0) ? (C'(1) << m_owner) : '0;
            er = (m_state == 1 && fr) ? (C'(1) << m_owner) : '0;
            check("in_valid", in_valid, m_ov);
            if (m_ov) check("in_data", in_data, m_od);
            check("grant", grant, eg);
            check("busy", busy, m_state != 0);
            check("req_ready", req_ready, er);
        end
    end

    // Record every byte handed to usb_cdc.
    always @(negedge clk) begin
        if (chk_en && rstn && in_valid && in_ready) begin
            out_log.push_back(in_data);
            out_cyc.push_back(cyc);
        end
    end

    task automatic drive();
        req_valid[0]  = (q0.size() != 0);
        req_data[7:0] = (q0.size() != 0) ? q0[0] : 8'h00;
        req_valid[1]  = (q1.size() != 0);
        req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic step();
        logic [C-1:0] hs;
        logic [7:0]   junk;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        if (rstn) begin
            if (hs[0]) junk = q0.pop_front();
            if (hs[1]) junk = q1.pop_front();
        end
        #1;
        drive();
    endtask

    task automatic run_until_out(input int n, input int budget, input string what);
        int b;
        b = 0;
        while (out_log.size() < n && b < budget) begin
            step();
            b++;
        end
        check(what, (out_log.size() >= n), 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        out_log.delete();
        out_cyc.delete();
    endtask

    initial begin
        rstn      = 1'b0;
        in_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset held 3 cycles with both channels requesting.
        for (int i = 0; i < 20; i++) begin
            q0.push_back(8'(i));
            q1.push_back(8'h80 + 8'(i));
        end
        drive();
        step();
        chk_en = 1'b1;
        step();
        step();
        check("rst_in_valid", in_valid, 0);
        check("rst_in_data", in_data, 8'h00);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        rstn = 1'b1;
        step();
        check("first_grant", grant, 2'b01);
        check("first_busy", busy, 1);
        $display("reset: grant after release = %b", grant);

`ifdef USB_IN_ARBITER_TAG_EN
        // Tag feature: one ch1 byte, then one ch0 byte.
        q0.delete(); q1.delete(); drive();
        do_reset();
        q1.push_back(8'h5A); drive();
        run_until_out(2, 40, "tag_timeout1");
        if (out_log.size() >= 2) begin
            check("tag_ch1", out_log[0], 8'hF1);
            check("tag_ch1_data", out_log[1], 8'h5A);
        end
        q0.push_back(8'h33); drive();
        run_until_out(4, 40, "tag_timeout2");
        if (out_log.size() >= 4) begin
            check("tag_ch0", out_log[2], 8'hF0);
            check("tag_ch0_data", out_log[3], 8'h33);
        end
        $display("tag: %0d bytes out", out_log.size());
`else
        // Burst limit: both channels stream continuously.
        out_log.delete(); out_cyc.delete();
        run_until_out(40, 400, "burst_timeout");
        if (out_log.size() >= 40) begin
            for (int i = 0; i < 40; i++) begin
                logic [7:0] e;
                if (i < 32) e = ((i / 8) % 2 == 0) ? 8'(i / 16 * 8 + i % 8) : 8'h80 + 8'(i / 16 * 8 + i % 8);
                else if (i < 36) e = 8'(16 + i - 32);
                else e = 8'h90 + 8'(i - 36);
                check("burst_seq", out_log[i], e);
            end
            for (int i = 1; i < 36; i++)
                check("burst_spacing", out_cyc[i] - out_cyc[i-1], (i % 8 == 0) ? 2 : 1);
        end
        $display("burst: %0d bytes out", out_log.size());

        // Requester gap: ch0 sends three bytes then stops.
        q0.delete(); q1.delete(); drive();
        do_reset();
        q0 = '{8'h11, 8'h22, 8'h33};
        q1 = '{8'hA1, 8'hA2};
        drive();
        run_until_out(5, 60, "gap_timeout");
        if (out_log.size() >= 5) begin
            check("gap_b0", out_log[0], 8'h11);
            check("gap_b1", out_log[1], 8'h22);
            check("gap_b2", out_log[2], 8'h33);
            check("gap_b3", out_log[3], 8'hA1);
            check("gap_b4", out_log[4], 8'hA2);
        end
        $display("gap: %0d bytes out", out_log.size());

        // Backpressure: in_ready low for 10 cycles mid-burst.
        q0.delete(); q1.delete(); drive();
        do_reset();
        for (int i = 0; i < 8; i++) q0.push_back(8'h40 + 8'(i));
        drive();
        run_until_out(3, 40, "bp_timeout1");
        in_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", in_valid, 1);
            check("bp_data", in_data, 8'h43);
            check("bp_ready", req_ready, 0);
            check("bp_grant", grant, 2'b01);
        end
        in_ready = 1'b1;
        run_until_out(8, 60, "bp_timeout2");
        check("bp_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("bp_seq", out_log[i], 8'h40 + 8'(i));
        $display("backpressure: %0d bytes out", out_log.size());

        // Reset in the middle of a ch1 burst.
        q0.delete(); q1.delete(); drive();
        do_reset();
        for (int i = 0; i < 8; i++) q1.push_back(8'h60 + 8'(i));
        drive();
        run_until_out(4, 40, "mid_timeout");
        rstn = 1'b0;
        q0.push_back(8'h70);
        drive();
        step();
        check("mid_valid", in_valid, 0);
        check("mid_grant", grant, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", req_ready, 0);
        rstn = 1'b1;
        step();
        check("mid_next_grant", grant, 2'b01);
        $display("mid-burst reset: next grant = %b", grant);
`endif

        repeat (20) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
